ram_memory_be: RTL and testbench

Simple dual-port RAM: one write port, one read port, one clock. Adds per-byte write enables, an explicit read enable with a valid strobe, and an optional output pipeline register. Read-during-write to the same address is selectable at build time. Intended as the storage core for next-generation FIFOs and line buffers that need byte-masked writes and a known read latency.

---
 rtl/ram_memory_be_if.sv | 27 ++
 rtl/ram_memory_be.sv | 85 ++++++++
 tb/tb_ram_memory_be.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_memory_be_if.sv
// Bus bundle for the byte-enabled dual-port RAM: a write channel, a read
// request channel and the read return (data plus valid strobe).
interface ram_memory_be_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
);
    logic                  wren_i;
    logic [AWIDTH-1:0]     wrpntr_i;
    logic [DWIDTH/8-1:0]   byteen_i;
    logic [DWIDTH-1:0]     data_i;
    logic                  rden_i;
    logic [AWIDTH-1:0]     rdpntr_i;
    logic [DWIDTH-1:0]     q_o;
    logic                  q_valid_o;

    // Requester side: issues writes and reads, receives read data.
    modport master (
        output wren_i, wrpntr_i, byteen_i, data_i, rden_i, rdpntr_i,
        input  q_o, q_valid_o
    );

    // Memory side: accepts writes and reads, returns read data.
    modport slave (
        input  wren_i, wrpntr_i, byteen_i, data_i, rden_i, rdpntr_i,
        output q_o, q_valid_o
    );
endinterface

// File: rtl/ram_memory_be.sv
// Simple dual-port RAM with per-byte write enables, a read enable with a
// matching valid strobe, an optional second output register and a selectable
// same-address read-during-write result (new merged data or old data).
// The array itself is never reset so it can map onto block RAM.
module ram_memory_be #(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 4,
    parameter int OUTREG  = 0,
    parameter int RDW_NEW = 1
) (
    input  logic            clk_i,
    input  logic            arst_n_i,
    ram_memory_be_if.slave  bus
);
    localparam int NBYTES = DWIDTH / 8;
    localparam int DEPTH  = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [DWIDTH-1:0] s1Data_d;
    logic [DWIDTH-1:0] s1Data_q;
    logic              s1Valid_q;

    // Byte-masked write; writes are dropped while reset is held.
    always_ff @(posedge clk_i) begin
        if (arst_n_i && bus.wren_i) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (bus.byteen_i[k]) begin
                    mem[bus.wrpntr_i][8*k +: 8] <= bus.data_i[8*k +: 8];
                end
            end
        end
    end

    // Read word with an explicit bypass so same-address writes can be seen.
    always_comb begin
        s1Data_d = mem[bus.rdpntr_i];
        if ((RDW_NEW != 0) && bus.wren_i && (bus.wrpntr_i == bus.rdpntr_i)) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (bus.byteen_i[k]) begin
                    s1Data_d[8*k +: 8] = bus.data_i[8*k +: 8];
                end
            end
        end
    end

    // First read stage: captures data on a read, otherwise holds it.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            s1Data_q  <= '0;
            s1Valid_q <= 1'b0;
        end else begin
            s1Valid_q <= bus.rden_i;
            if (bus.rden_i) begin
                s1Data_q <= s1Data_d;
            end
        end
    end

    generate
        if (OUTREG != 0) begin : gOutReg
            logic [DWIDTH-1:0] s2Data_q;
            logic              s2Valid_q;

            // Second stage only advances when the first stage holds a result.
            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) begin
                    s2Data_q  <= '0;
                    s2Valid_q <= 1'b0;
                end else begin
                    s2Valid_q <= s1Valid_q;
                    if (s1Valid_q) begin
                        s2Data_q <= s1Data_q;
                    end
                end
            end

            assign bus.q_o       = s2Data_q;
            assign bus.q_valid_o = s2Valid_q;
        end else begin : gNoOutReg
            assign bus.q_o       = s1Data_q;
            assign bus.q_valid_o = s1Valid_q;
        end
    endgenerate
endmodule

// File: tb/tb_ram_memory_be.sv
// Bench for ram_memory_be: two instances share one stimulus stream,
// dutA (latency 1, new-data read-during-write) and dutB (latency 2,
// old-data read-during-write). Read results are scoreboarded with their
// expected arrival cycle.
module tb_ram_memory_be;
    logic clk;
    logic arst_n;

    ram_memory_be_if #(.DWIDTH(32), .AWIDTH(4)) busA ();
    ram_memory_be_if #(.DWIDTH(32), .AWIDTH(4)) busB ();

    ram_memory_be #(.DWIDTH(32), .AWIDTH(4), .OUTREG(0), .RDW_NEW(1)) dutA (
        .clk_i(clk), .arst_n_i(arst_n), .bus(busA)
    );
    ram_memory_be #(.DWIDTH(32), .AWIDTH(4), .OUTREG(1), .RDW_NEW(0)) dutB (
        .clk_i(clk), .arst_n_i(arst_n), .bus(busB)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic        wren;
        logic [3:0]  wp;
        logic [3:0]  be;
        logic [31:0] data;
        logic        rden;
        logic [3:0]  rp;
        logic [31:0] expNew;
        logic [31:0] expOld;
    } vec_t;

    exp_t        qA[$];
    exp_t        qB[$];
    int          cycleCnt    = 0;
    int          assertCount = 0;
    int          failCount   = 0;
    logic [31:0] lastA       = 32'h0;
    logic [31:0] lastB       = 32'h0;

    // Free-running clock and cycle counter used for latency checks.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cycleCnt);
        end
    endtask

    // Drives one cycle on both buses and records expected read results.
    task automatic applyStimulus(input logic wr, input logic [3:0] wp, input logic [3:0] be,
                                 input logic [31:0] d, input logic rd, input logic [3:0] rp,
                                 input logic [31:0] expNew, input logic [31:0] expOld);
        busA.wren_i = wr; busA.wrpntr_i = wp; busA.byteen_i = be; busA.data_i = d;
        busA.rden_i = rd; busA.rdpntr_i = rp;
        busB.wren_i = wr; busB.wrpntr_i = wp; busB.byteen_i = be; busB.data_i = d;
        busB.rden_i = rd; busB.rdpntr_i = rp;
        if (rd && arst_n) begin
            qA.push_back('{data: expNew, due: cycleCnt + 1});
            qB.push_back('{data: expOld, due: cycleCnt + 2});
        end
        @(posedge clk);
        #1;
        busA.wren_i = 1'b0; busA.rden_i = 1'b0;
        busB.wren_i = 1'b0; busB.rden_i = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 32'h0, 32'h0);
    endtask

    // Quiet interval: no strobe may appear and both outputs must hold.
    task automatic holdCheck(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("holdValidA", {31'h0, busA.q_valid_o}, 32'h0);
            checkOutput("holdValidB", {31'h0, busB.q_valid_o}, 32'h0);
            checkOutput("holdDataA", busA.q_o, lastA);
            checkOutput("holdDataB", busB.q_o, lastB);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for dutA: every strobe must match the oldest pending read.
    always @(negedge clk) begin
        if (busA.q_valid_o) begin
            exp_t e;
            if (qA.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpectedValidA: got strobe with data 0x%08h expected none", busA.q_o);
            end else begin
                e = qA.pop_front();
                checkOutput("readDataA", busA.q_o, e.data);
                checkOutput("latencyA", cycleCnt, e.due);
                lastA = e.data;
            end
        end
    end

    // Scoreboard for dutB: every strobe must match the oldest pending read.
    always @(negedge clk) begin
        if (busB.q_valid_o) begin
            exp_t e;
            if (qB.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpectedValidB: got strobe with data 0x%08h expected none", busB.q_o);
            end else begin
                e = qB.pop_front();
                checkOutput("readDataB", busB.q_o, e.data);
                checkOutput("latencyB", cycleCnt, e.due);
                lastB = e.data;
            end
        end
    end

    initial begin
        vec_t vecs[18];
        vecs[0]  = '{1'b1, 4'd3,  4'hF, 32'hDEADBEEF, 1'b0, 4'd0,  32'h0,        32'h0};
        vecs[1]  = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd3,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'd5,  4'hF, 32'h11223344, 1'b0, 4'd0,  32'h0,        32'h0};
        vecs[3]  = '{1'b1, 4'd5,  4'h5, 32'hAABBCCDD, 1'b0, 4'd0,  32'h0,        32'h0};
        vecs[4]  = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd5,  32'h11BB33DD, 32'h11BB33DD};
        vecs[5]  = '{1'b1, 4'd7,  4'hF, 32'h00000000, 1'b0, 4'd0,  32'h0,        32'h0};
        vecs[6]  = '{1'b1, 4'd7,  4'h3, 32'hFFFFFFFF, 1'b1, 4'd7,  32'h0000FFFF, 32'h00000000};
        vecs[7]  = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd7,  32'h0000FFFF, 32'h0000FFFF};
        vecs[8]  = '{1'b1, 4'd9,  4'hF, 32'h12345678, 1'b0, 4'd0,  32'h0,        32'h0};
        vecs[9]  = '{1'b1, 4'd9,  4'h0, 32'hFFFFFFFF, 1'b0, 4'd0,  32'h0,        32'h0};
        vecs[10] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd9,  32'h12345678, 32'h12345678};
        vecs[11] = '{1'b1, 4'd10, 4'hF, 32'hCAFEF00D, 1'b1, 4'd3,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[12] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd10, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[13] = '{1'b1, 4'd15, 4'hF, 32'hA5A5A5A5, 1'b0, 4'd0,  32'h0,        32'h0};
        vecs[14] = '{1'b1, 4'd3,  4'h8, 32'h77000000, 1'b1, 4'd15, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[15] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd3,  32'h77ADBEEF, 32'h77ADBEEF};
        vecs[16] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd5,  32'h11BB33DD, 32'h11BB33DD};
        vecs[17] = '{1'b1, 4'd9,  4'h0, 32'h00000000, 1'b1, 4'd9,  32'h12345678, 32'h12345678};

        busA.wren_i = 1'b0; busA.wrpntr_i = '0; busA.byteen_i = '0; busA.data_i = '0;
        busA.rden_i = 1'b0; busA.rdpntr_i = '0;
        busB.wren_i = 1'b0; busB.wrpntr_i = '0; busB.byteen_i = '0; busB.data_i = '0;
        busB.rden_i = 1'b0; busB.rdpntr_i = '0;
        arst_n = 1'b0;

        // Reset values.
        #2;
        checkOutput("resetDataA", busA.q_o, 32'h0);
        checkOutput("resetValidA", {31'h0, busA.q_valid_o}, 32'h0);
        checkOutput("resetDataB", busB.q_o, 32'h0);
        checkOutput("resetValidB", {31'h0, busB.q_valid_o}, 32'h0);
        @(posedge clk);
        #3 arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven writes and reads.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].wren, vecs[i].wp, vecs[i].be, vecs[i].data,
                          vecs[i].rden, vecs[i].rp, vecs[i].expNew, vecs[i].expOld);
        end
        idleCycles(3);
        holdCheck(10);

        // Streaming: fill 0..15 with value = address, then 16 back-to-back reads.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'(i), 4'hF, 32'(i), 1'b0, 4'd0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'(i), 32'(i), 32'(i));
        idleCycles(3);
        holdCheck(3);

        // Reset while a read is in flight: no strobe, outputs cleared at once.
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd2, 32'd2, 32'd2);
        #2 arst_n = 1'b0;
        qA.delete();
        qB.delete();
        lastA = 32'h0;
        lastB = 32'h0;
        #1;
        checkOutput("midResetDataA", busA.q_o, 32'h0);
        checkOutput("midResetValidA", {31'h0, busA.q_valid_o}, 32'h0);
        checkOutput("midResetDataB", busB.q_o, 32'h0);
        checkOutput("midResetValidB", {31'h0, busB.q_valid_o}, 32'h0);
        @(posedge clk);
        #1;
        // A write attempted during reset must not land.
        applyStimulus(1'b1, 4'd2, 4'hF, 32'hDEAD0000, 1'b0, 4'd0, 32'h0, 32'h0);
        #2 arst_n = 1'b1;
        @(posedge clk);
        #1;
        holdCheck(3);
        applyStimulus(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd2, 32'd2, 32'd2);

        // Let all outstanding reads drain, bounded.
        for (int i = 0; i < 20 && (qA.size() != 0 || qB.size() != 0); i++) idleCycles(1);
        checkOutput("drainA", qA.size(), 32'h0);
        checkOutput("drainB", qB.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
